// File: rtl/xgmii_lb_pkg.sv
// Shared FSM state type and XGMII control-character constants for the loopback checker.
package xgmii_lb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_HUNT   = 2'd2,
    ST_LOCKED = 2'd3
  } lb_state_e;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;

  function automatic logic is_compare_state(input lb_state_e s);
    return (s == ST_HUNT) || (s == ST_LOCKED);
  endfunction

endpackage

// File: rtl/xgmii_lb_delay_line.sv
// Shift-register delay line with a selectable tap; the MSB of each word is a valid flag
// and is the only bit cleared by reset.
module xgmii_lb_delay_line #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic [$clog2(DEPTH):0]     sel_i,
  output logic [WIDTH-1:0]           tap_o
);

  localparam int SEL_W = $clog2(DEPTH) + 1;

  logic             vld_q [DEPTH];
  logic [WIDTH-2:0] dat_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) vld_q[i] <= 1'b0;
    end else begin
      vld_q[0] <= din_i[WIDTH-1];
      for (int i = 1; i < DEPTH; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    dat_q[0] <= din_i[WIDTH-2:0];
    for (int i = 1; i < DEPTH; i++) dat_q[i] <= dat_q[i-1];
  end

  // Entry k holds the word presented k+1 cycles ago, so select n maps to entry n-1.
  always_comb begin
    tap_o = {vld_q[0], dat_q[0]};
    for (int i = 1; i < DEPTH; i++) begin
      if (sel_i == SEL_W'(i + 1)) tap_o = {vld_q[i], dat_q[i]};
    end
  end

endmodule

// File: rtl/xgmii_lb_checker.sv
// XGMII loopback checker: compares RX against TX delayed by i_latency and tracks lock.
// Optional first-mismatch capture ports are enabled by defining XGMII_LB_ERR_CAPTURE_EN.
module xgmii_lb_checker
  import xgmii_lb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_LATENCY = 16,
  parameter int CNT_WIDTH   = 32,
  parameter int LOCK_CNT    = 8,
  parameter int UNLOCK_CNT  = 4
) (
  input  logic                          gty_usr_clk,
  input  logic                          gty_usr_reset,
  input  logic [DATA_WIDTH-1:0]         i_xgmii_txd,
  input  logic [DATA_WIDTH/8-1:0]       i_xgmii_txc,
  input  logic                          i_xgmii_valid,
  input  logic [DATA_WIDTH-1:0]         i_xgmii_rxd,
  input  logic [DATA_WIDTH/8-1:0]       i_xgmii_rxc,
  input  logic                          i_xgmii_rvalid,
  input  logic [$clog2(MAX_LATENCY):0]  i_latency,
  input  logic                          i_clear,
  output logic [CNT_WIDTH-1:0]          o_match_cnt,
  output logic [CNT_WIDTH-1:0]          o_err_cnt,
  output logic                          o_err,
  output logic                          o_locked,
  output logic [1:0]                    o_state
`ifdef XGMII_LB_ERR_CAPTURE_EN
  ,
  output logic [DATA_WIDTH-1:0]         o_cap_exp_d,
  output logic [DATA_WIDTH/8-1:0]       o_cap_exp_c,
  output logic [DATA_WIDTH-1:0]         o_cap_act_d,
  output logic [DATA_WIDTH/8-1:0]       o_cap_act_c,
  output logic                          o_cap_valid
`endif
);

  localparam int CTRL_WIDTH = DATA_WIDTH / 8;
  localparam int LAT_W      = $clog2(MAX_LATENCY) + 1;
  localparam int LINE_W     = 1 + CTRL_WIDTH + DATA_WIDTH;
  localparam int HR_W       = $clog2(LOCK_CNT + 1);
  localparam int UR_W       = $clog2(UNLOCK_CNT + 1);

  function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] l);
    if (l == '0) return LAT_W'(1);
    else if (l > LAT_W'(MAX_LATENCY)) return LAT_W'(MAX_LATENCY);
    else return l;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  lb_state_e              state_q;
  logic [LAT_W-1:0]       lat_q;
  logic [LAT_W-1:0]       fill_q;
  logic [HR_W-1:0]        hunt_run_q;
  logic [UR_W-1:0]        miss_run_q;
  logic [CNT_WIDTH-1:0]   match_cnt_q;
  logic [CNT_WIDTH-1:0]   err_cnt_q;
  logic                   err_q;
  logic                   locked_q;

  logic [LAT_W-1:0]       lat_c;
  logic [LINE_W-1:0]      tap;
  logic                   tap_v;
  logic [CTRL_WIDTH-1:0]  tap_c;
  logic [DATA_WIDTH-1:0]  tap_d;
  logic                   miss;
  logic                   cmp_en;

  assign lat_c = clamp_lat(i_latency);

  xgmii_lb_delay_line #(
    .WIDTH (LINE_W),
    .DEPTH (MAX_LATENCY)
  ) u_delay (
    .clk_i (gty_usr_clk),
    .rst_i (gty_usr_reset),
    .din_i ({i_xgmii_valid, i_xgmii_txc, i_xgmii_txd}),
    .sel_i (lat_c),
    .tap_o (tap)
  );

  assign {tap_v, tap_c, tap_d} = tap;
  assign miss   = !tap_v || (tap_c != i_xgmii_rxc) || (tap_d != i_xgmii_rxd);
  // A latency change or clear pre-empts comparison in the same cycle.
  assign cmp_en = i_xgmii_rvalid && !i_clear && (lat_c == lat_q) && is_compare_state(state_q);

  always_ff @(posedge gty_usr_clk or posedge gty_usr_reset) begin
    if (gty_usr_reset) begin
      state_q     <= ST_IDLE;
      lat_q       <= LAT_W'(1);
      fill_q      <= '0;
      hunt_run_q  <= '0;
      miss_run_q  <= '0;
      match_cnt_q <= '0;
      err_cnt_q   <= '0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      lat_q <= lat_c;
      err_q <= 1'b0;
      if (i_clear) begin
        state_q     <= ST_FILL;
        fill_q      <= '0;
        hunt_run_q  <= '0;
        miss_run_q  <= '0;
        match_cnt_q <= '0;
        err_cnt_q   <= '0;
        locked_q    <= 1'b0;
      end else if (state_q == ST_IDLE) begin
        state_q <= ST_FILL;
        fill_q  <= '0;
      end else if (lat_c != lat_q) begin
        state_q    <= ST_FILL;
        fill_q     <= '0;
        hunt_run_q <= '0;
        miss_run_q <= '0;
        locked_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_FILL: begin
            if (fill_q == lat_c - LAT_W'(1)) state_q <= ST_HUNT;
            else fill_q <= fill_q + LAT_W'(1);
          end
          ST_HUNT: begin
            if (cmp_en) begin
              if (miss) begin
                err_q      <= 1'b1;
                err_cnt_q  <= sat_inc(err_cnt_q);
                hunt_run_q <= '0;
              end else begin
                match_cnt_q <= sat_inc(match_cnt_q);
                if (hunt_run_q == HR_W'(LOCK_CNT - 1)) begin
                  state_q    <= ST_LOCKED;
                  locked_q   <= 1'b1;
                  hunt_run_q <= '0;
                  miss_run_q <= '0;
                end else begin
                  hunt_run_q <= hunt_run_q + HR_W'(1);
                end
              end
            end
          end
          ST_LOCKED: begin
            if (cmp_en) begin
              if (miss) begin
                err_q     <= 1'b1;
                err_cnt_q <= sat_inc(err_cnt_q);
                if (miss_run_q == UR_W'(UNLOCK_CNT - 1)) begin
                  state_q    <= ST_HUNT;
                  locked_q   <= 1'b0;
                  miss_run_q <= '0;
                  hunt_run_q <= '0;
                end else begin
                  miss_run_q <= miss_run_q + UR_W'(1);
                end
              end else begin
                match_cnt_q <= sat_inc(match_cnt_q);
                miss_run_q  <= '0;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_match_cnt = match_cnt_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_err       = err_q;
  assign o_locked    = locked_q;
  assign o_state     = state_q;

`ifdef XGMII_LB_ERR_CAPTURE_EN
  logic                  cap_valid_q;
  logic [DATA_WIDTH-1:0] cap_exp_d_q;
  logic [CTRL_WIDTH-1:0] cap_exp_c_q;
  logic [DATA_WIDTH-1:0] cap_act_d_q;
  logic [CTRL_WIDTH-1:0] cap_act_c_q;
  logic                  cap_take;

  assign cap_take = cmp_en && miss && !cap_valid_q;

  always_ff @(posedge gty_usr_clk or posedge gty_usr_reset) begin
    if (gty_usr_reset) cap_valid_q <= 1'b0;
    else if (i_clear)  cap_valid_q <= 1'b0;
    else if (cap_take) cap_valid_q <= 1'b1;
  end

  always_ff @(posedge gty_usr_clk) begin
    if (cap_take) begin
      cap_exp_d_q <= tap_d;
      cap_exp_c_q <= tap_c;
      cap_act_d_q <= i_xgmii_rxd;
      cap_act_c_q <= i_xgmii_rxc;
    end
  end

  assign o_cap_exp_d = cap_exp_d_q;
  assign o_cap_exp_c = cap_exp_c_q;
  assign o_cap_act_d = cap_act_d_q;
  assign o_cap_act_c = cap_act_c_q;
  assign o_cap_valid = cap_valid_q;
`endif

endmodule

// File: tb/tb_xgmii_lb_checker.sv
// Scoreboard bench for xgmii_lb_checker: a behavioural loopback plus expected-result queue.
module tb_xgmii_lb_checker;
  import xgmii_lb_pkg::*;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int ML = 16;
  localparam int LW = 5;
  localparam int LOCK = 8;
  localparam int UNLOCK = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] txd, rxd;
  logic [CW-1:0] txc, rxc;
  logic txv, rxv, clr;
  logic [LW-1:0] lat;
  logic [31:0] mcnt, ecnt;
  logic err, locked;
  logic [1:0] st;
  logic [3:0] mcnt4, ecnt4;
  logic err4, locked4;
  logic [1:0] st4;
`ifdef XGMII_LB_ERR_CAPTURE_EN
  logic [DW-1:0] c1_ed, c1_ad, c2_ed, c2_ad;
  logic [CW-1:0] c1_ec, c1_ac, c2_ec, c2_ac;
  logic c1_v, c2_v;
`endif

  xgmii_lb_checker #(.DATA_WIDTH(DW), .MAX_LATENCY(ML), .CNT_WIDTH(32)) dut (
    .gty_usr_clk(clk), .gty_usr_reset(rst),
    .i_xgmii_txd(txd), .i_xgmii_txc(txc), .i_xgmii_valid(txv),
    .i_xgmii_rxd(rxd), .i_xgmii_rxc(rxc), .i_xgmii_rvalid(rxv),
    .i_latency(lat), .i_clear(clr),
    .o_match_cnt(mcnt), .o_err_cnt(ecnt), .o_err(err), .o_locked(locked), .o_state(st)
`ifdef XGMII_LB_ERR_CAPTURE_EN
    , .o_cap_exp_d(c1_ed), .o_cap_exp_c(c1_ec), .o_cap_act_d(c1_ad), .o_cap_act_c(c1_ac),
    .o_cap_valid(c1_v)
`endif
  );

  xgmii_lb_checker #(.DATA_WIDTH(DW), .MAX_LATENCY(ML), .CNT_WIDTH(4)) dut4 (
    .gty_usr_clk(clk), .gty_usr_reset(rst),
    .i_xgmii_txd(txd), .i_xgmii_txc(txc), .i_xgmii_valid(txv),
    .i_xgmii_rxd(rxd), .i_xgmii_rxc(rxc), .i_xgmii_rvalid(rxv),
    .i_latency(lat), .i_clear(clr),
    .o_match_cnt(mcnt4), .o_err_cnt(ecnt4), .o_err(err4), .o_locked(locked4), .o_state(st4)
`ifdef XGMII_LB_ERR_CAPTURE_EN
    , .o_cap_exp_d(c2_ed), .o_cap_exp_c(c2_ec), .o_cap_act_d(c2_ad), .o_cap_act_c(c2_ac),
    .o_cap_valid(c2_v)
`endif
  );

  typedef struct {
    logic err;
    int   mc;
    int   ec;
    logic lk;
    int   st;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  logic [DW-1:0] h_d [0:4095];
  logic [CW-1:0] h_c [0:4095];
  logic          h_v [0:4095];
  int cyc = 0;
  int rst_cyc = 0;
  int dly = 6;
  logic [DW-1:0] seq = 32'h0000_0100;

  int m_st, m_fill, m_hrun, m_urun, m_mc, m_ec, m_lat;
  logic m_err;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_fill = 0; m_hrun = 0; m_urun = 0; m_mc = 0; m_ec = 0; m_lat = 1; m_err = 1'b0;
  endtask

  task automatic model_step();
    int lc, idx;
    logic ok;
    lc = (lat == 0) ? 1 : ((int'(lat) > ML) ? ML : int'(lat));
    m_err = 1'b0;
    if (clr) begin
      m_st = 1; m_fill = 0; m_mc = 0; m_ec = 0; m_hrun = 0; m_urun = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_fill = 0;
    end else if (lc != m_lat) begin
      m_st = 1; m_fill = 0; m_hrun = 0; m_urun = 0;
    end else if (m_st == 1) begin
      m_fill++;
      if (m_fill == lc) m_st = 2;
    end else if (rxv) begin
      idx = cyc - lc;
      ok = (idx >= rst_cyc) && h_v[idx] && (h_d[idx] == rxd) && (h_c[idx] == rxc);
      if (ok) begin
        m_mc++;
        if (m_st == 2) begin
          m_hrun++;
          if (m_hrun == LOCK) begin m_st = 3; m_hrun = 0; end
        end else m_urun = 0;
      end else begin
        m_ec++;
        m_err = 1'b1;
        if (m_st == 2) m_hrun = 0;
        else begin
          m_urun++;
          if (m_urun == UNLOCK) begin m_st = 2; m_urun = 0; m_hrun = 0; end
        end
      end
    end
    m_lat = lc;
  endtask

  task automatic drive(input logic v, input logic bad_rx);
    exp_t e;
    if (v) begin txd = seq; txc = '0; seq = seq + 1; end
    else begin txd = {4{XGMII_IDLE}}; txc = 4'hF; end
    txv = v;
    h_d[cyc] = txd; h_c[cyc] = txc; h_v[cyc] = v;
    if (cyc >= dly) begin
      rxd = h_d[cyc-dly]; rxc = h_c[cyc-dly]; rxv = h_v[cyc-dly];
    end else begin
      rxd = '0; rxc = '0; rxv = 1'b0;
    end
    if (bad_rx) rxd[0] = ~rxd[0];
    model_step();
    e.err = m_err; e.mc = m_mc; e.ec = m_ec; e.lk = (m_st == 3); e.st = m_st;
    sbq.push_back(e);
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk("err", err, e.err);
    chk("match_cnt", mcnt, e.mc);
    chk("err_cnt", ecnt, e.ec);
    chk("locked", locked, e.lk);
    chk("state", st, e.st);
    chk("match_cnt4", mcnt4, (e.mc > 15) ? 15 : e.mc);
    chk("err_cnt4", ecnt4, (e.ec > 15) ? 15 : e.ec);
    chk("locked4", locked4, e.lk);
    cyc++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mcnt"}, mcnt, 0);
    chk({tag, "_ecnt"}, ecnt, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_state"}, st, 0);
    chk({tag, "_mcnt4"}, mcnt4, 0);
  endtask

  int npulse;
  logic ever_lk;

  initial begin
    txd = '0; txc = '0; txv = 1'b0; rxd = '0; rxc = '0; rxv = 1'b0; clr = 1'b0; lat = 5'd6;
    #1 rst = 1'b1;
    #1 chk_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    rst_cyc = cyc;
    model_reset();

    // Clean 6-cycle loopback, 100 words.
    dly = 6;
    repeat (10) drive(1'b0, 1'b0);
    repeat (100) drive(1'b1, 1'b0);
    repeat (6) drive(1'b0, 1'b0);
    chk("s1_match", mcnt, 100);
    chk("s1_err", ecnt, 0);
    chk("s1_locked", locked, 1);
    chk("sat_match4", mcnt4, 15);

    // Single flipped bit while locked.
    npulse = 0;
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, k == 20);
      if (err) npulse++;
    end
    chk("s2_pulses", npulse, 1);
    chk("s2_err", ecnt, 1);
    chk("s2_locked", locked, 1);

    // Four consecutive corrupt words drop lock; eight clean words restore it.
    for (int k = 0; k < 14; k++) drive(1'b1, (k >= 10) && (k <= 13));
    chk("s3_unlocked", locked, 0);
    chk("s3_hunt", st, ST_HUNT);
    repeat (8) drive(1'b1, 1'b0);
    chk("s3_relock", locked, 1);

    // Wrong latency: every compare mismatches, never locks.
    lat = 5'd5;
    ever_lk = 1'b0;
    repeat (40) begin
      drive(1'b1, 1'b0);
      ever_lk = ever_lk | locked;
    end
    chk("s4_neverlock", ever_lk, 0);

    lat = 5'd6;
    repeat (20) drive(1'b1, 1'b0);
    chk("s5_locked", locked, 1);

    // Clear with a simultaneous mismatch.
    clr = 1'b1;
    drive(1'b1, 1'b1);
    clr = 1'b0;
    chk("s6_mcnt", mcnt, 0);
    chk("s6_ecnt", ecnt, 0);
    chk("s6_err", err, 0);
    chk("s6_fill", st, ST_FILL);
    for (int k = 1; k <= 14; k++) begin
      drive(1'b1, 1'b0);
      if (k == 13) chk("s6_not_yet", locked, 0);
    end
    chk("s6_relock", locked, 1);

    // Latency clamping at both ends.
    lat = 5'd0; dly = 1;
    repeat (12) drive(1'b1, 1'b0);
    chk("s7_lat0_locked", locked, 1);
    lat = 5'd20; dly = 16;
    repeat (30) drive(1'b1, 1'b0);
    chk("s7_latmax_locked", locked, 1);
    chk("s7_latmax_state", st, ST_LOCKED);

    // Asynchronous reset mid-stream.
    #2 rst = 1'b1;
    #1 chk_zero("midrst");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    rst_cyc = cyc;
    model_reset();
    repeat (28) drive(1'b1, 1'b0);
    chk("s8_relock", locked, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
